painterengine_gpu_reader_arbiter: RTL
=====================================

// Module: painterengine_gpu_reader_arbiter
// PURPOSE
//  Shares one DMA burst reader between two requesters: port 0 = display streamer, port 1 = blitter/texture fetch.
//  Each requester sees a private reader-style port (address/length/resetn in; done/error/data/valid out; data_next in).
//  Single clock domain i_wire_clock; sits between the requesters and the AXI DMA reader.
// PARAMETERS
//  PARAM_TIMEOUT  65535  max cycles per burst in RUN before a forced error; 0 disables the watchdog
// PORTS
//  i_wire_clock              in   1   system clock
//  i_wire_resetn             in   1   async active-low reset
//  i_wire_reqN_address       in   32  burst byte address, N=0,1; must be stable while reqN_resetn=1
//  i_wire_reqN_length        in   32  burst length in 32-bit words, N=0,1
//  i_wire_reqN_resetn        in   1   1 = request/hold burst; 0 = close/abort, N=0,1
//  o_wire_reqN_done          out  1   burst complete, held until reqN_resetn=0
//  o_wire_reqN_error         out  1   reader error or timeout, held until reqN_resetn=0
//  o_wire_reqN_data          out  32  = i_wire_reader_data
//  o_wire_reqN_data_valid    out  1   reader valid gated by grant N
//  i_wire_reqN_data_next     in   1   requester can accept a word
//  o_wire_reader_address     out  32  latched address of granted burst
//  o_wire_reader_length      out  32  latched length of granted burst
//  o_wire_reader_resetn      out  1   1 = reader runs
//  i_wire_reader_done        in   1   reader burst complete
//  i_wire_reader_error       in   1   reader bus error
//  i_wire_reader_data        in   32  reader data
//  i_wire_reader_data_valid  in   1   reader data valid
//  o_wire_reader_data_next   out  1   = data_next of granted port; 0 when no grant
//  o_wire_grant              out  2   one-hot grant; 00 = none
//  o_wire_state              out  32  {27'd0, last_grant, state[2:0], timeout_flag}
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; last_grant=1, so port 0 wins the first tie; timeout counter 0.
//  States: IDLE(0) RUN(1) HOLD(2) GAP(3).
//  IDLE: sample reqN_resetn. Only one request high -> grant it. Both high -> grant !last_grant (round robin).
//   On grant, latch address/length, set grant and last_grant, clear counter, go RUN next cycle.
//   o_wire_reader_resetn=1 from the cycle after the request was sampled (1-cycle latency).
//   Granted length==0 -> skip RUN: assert done, go HOLD; reader resetn stays 0.
//  RUN: data/valid/data_next routed combinationally; ungranted port sees valid=0, done=0, error=0.
//   reader_error -> error to granted port, reader_resetn=0, go HOLD (error wins if error and done are both high).
//   reader_done -> done to granted port, reader_resetn=0, go HOLD.
//   granted reqN_resetn=0 (abort) -> reader_resetn=0, no done/error, go GAP.
//   counter reaches PARAM_TIMEOUT-1 with no done -> error, timeout_flag=1 (sticky until reset), go HOLD.
//   Counter is 32-bit and saturates; it is not used when PARAM_TIMEOUT=0.
//  HOLD: done/error held; reader_resetn=0; wait for granted reqN_resetn=0, then clear done/error and go GAP.
//  GAP: grant=00, reader_resetn=0 for exactly 1 cycle, then IDLE.
//   Guarantees >=1 reader reset cycle between bursts.
//  A requester keeping resetn=1 after done is never regranted: HOLD waits for its close.
//  Address/length changes while granted are ignored (latched copy used).
//  Async reset mid-burst: outputs 0 immediately; the reader is closed by reader_resetn=0.
// TESTING
//  req0 len=16 @0x1000 only -> grant=01, reader addr 0x1000 len 16, 16 words reach port 0 only, done0, GAP, IDLE.
//  req0 and req1 raised together, each re-requests after done -> grants 01,10,01,10 (alternating), never 11.
//  Blocked stream: req1 len=0 -> done1 within 2 cycles, reader_resetn never 1. Error: req0, reader_error=1 -> error0 held, done0=0.
//  PARAM_TIMEOUT=8, reader silent -> error on the 8th RUN cycle, o_wire_state[0]=1.
//  req0 drops resetn mid-burst (5 of 32 words) -> reader_resetn=0 next cycle, GAP, then pending req1 granted.
//  Assert i_wire_resetn=0 during RUN -> grant=00, reader_resetn=0, state IDLE; the next tie goes to port 0.

Source files
------------

// File: rtl/painterengine_gpu_reader_arbiter.sv
// Purpose : shares one DMA burst reader between display streamer (port 0) and blitter (port 1), round robin on ties.
// Latency : grant and reader_resetn register one cycle after a request is sampled in IDLE; data/valid/next are combinational.
// Backpressure: reader data_next follows the granted port's data_next; the ungranted port never sees valid.
//
// Ports:
//   i_wire_clock, i_wire_resetn (async active-low)
//   i_wire_reqN_{address,length,resetn,data_next}  requester N inputs (N=0,1)
//   o_wire_reqN_{done,error,data,data_valid}       requester N outputs
//   o_wire_reader_{address,length,resetn,data_next} to the DMA reader
//   i_wire_reader_{done,error,data,data_valid}     from the DMA reader
//   o_wire_grant (one-hot), o_wire_state {27'd0, last_grant, state[2:0], timeout_flag}
module painterengine_gpu_reader_arbiter #(
    parameter int unsigned PARAM_TIMEOUT = 65535
) (
    input  logic        i_wire_clock,
    input  logic        i_wire_resetn,

    input  logic [31:0] i_wire_req0_address,
    input  logic [31:0] i_wire_req0_length,
    input  logic        i_wire_req0_resetn,
    output logic        o_wire_req0_done,
    output logic        o_wire_req0_error,
    output logic [31:0] o_wire_req0_data,
    output logic        o_wire_req0_data_valid,
    input  logic        i_wire_req0_data_next,

    input  logic [31:0] i_wire_req1_address,
    input  logic [31:0] i_wire_req1_length,
    input  logic        i_wire_req1_resetn,
    output logic        o_wire_req1_done,
    output logic        o_wire_req1_error,
    output logic [31:0] o_wire_req1_data,
    output logic        o_wire_req1_data_valid,
    input  logic        i_wire_req1_data_next,

    output logic [31:0] o_wire_reader_address,
    output logic [31:0] o_wire_reader_length,
    output logic        o_wire_reader_resetn,
    input  logic        i_wire_reader_done,
    input  logic        i_wire_reader_error,
    input  logic [31:0] i_wire_reader_data,
    input  logic        i_wire_reader_data_valid,
    output logic        o_wire_reader_data_next,

    output logic [1:0]  o_wire_grant,
    output logic [31:0] o_wire_state
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_HOLD = 3'd2,
        ST_GAP  = 3'd3
    } state_t;

    // Counter value at which a silent burst is declared dead; unused when the watchdog is off.
    localparam logic [31:0] TIMEOUT_LAST = (PARAM_TIMEOUT == 0) ? 32'd0 : 32'(PARAM_TIMEOUT - 1);
    localparam bit          TIMEOUT_EN   = (PARAM_TIMEOUT != 0);

    state_t      state;
    logic [1:0]  grant;
    logic        last_grant;
    logic [31:0] addr_q;
    logic [31:0] len_q;
    logic        reader_resetn_q;
    logic        done_q;
    logic        error_q;
    logic        timeout_flag;
    logic [31:0] counter;

    logic        pick_vld;
    logic        pick_port;
    logic [31:0] pick_addr;
    logic [31:0] pick_len;
    logic        granted_resetn;
    logic        timeout_hit;
    logic        run;

    // Round robin only matters on a tie; a lone request always wins.
    always_comb begin
        pick_vld = i_wire_req0_resetn | i_wire_req1_resetn;
        if (i_wire_req0_resetn && i_wire_req1_resetn)
            pick_port = ~last_grant;
        else
            pick_port = i_wire_req1_resetn;
        pick_addr = pick_port ? i_wire_req1_address : i_wire_req0_address;
        pick_len  = pick_port ? i_wire_req1_length  : i_wire_req0_length;
    end

    assign granted_resetn = (grant[0] & i_wire_req0_resetn) | (grant[1] & i_wire_req1_resetn);
    assign timeout_hit    = TIMEOUT_EN && (counter == TIMEOUT_LAST);
    assign run            = (state == ST_RUN);

    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            state           <= ST_IDLE;
            grant           <= 2'b00;
            last_grant      <= 1'b1;
            addr_q          <= 32'd0;
            len_q           <= 32'd0;
            reader_resetn_q <= 1'b0;
            done_q          <= 1'b0;
            error_q         <= 1'b0;
            timeout_flag    <= 1'b0;
            counter         <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        grant      <= pick_port ? 2'b10 : 2'b01;
                        last_grant <= pick_port;
                        addr_q     <= pick_addr;
                        len_q      <= pick_len;
                        counter    <= 32'd0;
                        // An empty burst never wakes the reader.
                        if (pick_len == 32'd0) begin
                            done_q <= 1'b1;
                            state  <= ST_HOLD;
                        end else begin
                            reader_resetn_q <= 1'b1;
                            state           <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (counter != 32'hFFFF_FFFF)
                        counter <= counter + 32'd1;
                    if (i_wire_reader_error) begin
                        error_q         <= 1'b1;
                        reader_resetn_q <= 1'b0;
                        state           <= ST_HOLD;
                    end else if (i_wire_reader_done) begin
                        done_q          <= 1'b1;
                        reader_resetn_q <= 1'b0;
                        state           <= ST_HOLD;
                    end else if (!granted_resetn) begin
                        reader_resetn_q <= 1'b0;
                        grant           <= 2'b00;
                        state           <= ST_GAP;
                    end else if (timeout_hit) begin
                        error_q         <= 1'b1;
                        timeout_flag    <= 1'b1;
                        reader_resetn_q <= 1'b0;
                        state           <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // Status stays visible until the owner closes; it cannot be regranted meanwhile.
                    if (!granted_resetn) begin
                        done_q  <= 1'b0;
                        error_q <= 1'b0;
                        grant   <= 2'b00;
                        state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_wire_req0_done       = done_q  & grant[0];
    assign o_wire_req1_done       = done_q  & grant[1];
    assign o_wire_req0_error      = error_q & grant[0];
    assign o_wire_req1_error      = error_q & grant[1];
    assign o_wire_req0_data       = i_wire_reader_data;
    assign o_wire_req1_data       = i_wire_reader_data;
    assign o_wire_req0_data_valid = i_wire_reader_data_valid & grant[0] & run;
    assign o_wire_req1_data_valid = i_wire_reader_data_valid & grant[1] & run;
    assign o_wire_reader_data_next = run & ((grant[0] & i_wire_req0_data_next) |
                                            (grant[1] & i_wire_req1_data_next));

    assign o_wire_reader_address = addr_q;
    assign o_wire_reader_length  = len_q;
    assign o_wire_reader_resetn  = reader_resetn_q;
    assign o_wire_grant          = grant;
    assign o_wire_state          = {27'd0, last_grant, state, timeout_flag};

endmodule
